// File: rtl/cpu_regbank.sv
// Game Boy CPU register bank: A, F, B, C, D, E, H, L, SP and PC.
// Feeds ALU operands/flags combinationally and takes ALU write-back, flag
// updates, 16-bit INC/DEC and PC sequencing on the rising clock edge.
module cpu_regbank #(
    parameter bit          BOOT_SKIP = 1'b0,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  selX,
    input  logic [3:0]  selY,
    output logic [15:0] X,
    output logic [15:0] Y,
    output logic [3:0]  flags,
    input  logic        wrEn,
    input  logic [3:0]  wrSel,
    input  logic [15:0] wrData,
    input  logic        flagWrEn,
    input  logic [3:0]  flagMask,
    input  logic [3:0]  flagIn,
    input  logic        idEn,
    input  logic [1:0]  idSel,
    input  logic        idDec,
    input  logic        pcInc,
    input  logic        pcLoad,
    input  logic [15:0] pcIn,
    output logic [15:0] pc
);

    // Post-boot DMG values when BOOT_SKIP is set, otherwise zeros.
    localparam logic [7:0]  RstA  = BOOT_SKIP ? 8'h01 : 8'h00;
    localparam logic [3:0]  RstF  = BOOT_SKIP ? 4'hB : 4'h0;
    localparam logic [7:0]  RstB  = 8'h00;
    localparam logic [7:0]  RstC  = BOOT_SKIP ? 8'h13 : 8'h00;
    localparam logic [7:0]  RstD  = 8'h00;
    localparam logic [7:0]  RstE  = BOOT_SKIP ? 8'hD8 : 8'h00;
    localparam logic [7:0]  RstH  = BOOT_SKIP ? 8'h01 : 8'h00;
    localparam logic [7:0]  RstL  = BOOT_SKIP ? 8'h4D : 8'h00;
    localparam logic [15:0] RstSp = BOOT_SKIP ? 16'hFFFE : 16'h0000;
    localparam logic [15:0] RstPc = BOOT_SKIP ? 16'h0100 : RESET_PC;

    // F holds only its upper nibble {Z,N,H,C}; the low nibble reads as zero.
    logic [7:0]  aQ, bQ, cQ, dQ, eQ, hQ, lQ;
    logic [7:0]  aD, bD, cD, dD, eD, hD, lD;
    logic [3:0]  fQ, fD;
    logic [15:0] spQ, spD, pcQ, pcD;

    logic [15:0] rd [16];
    logic        idConflict;
    logic [15:0] idPair, idResult;

    // Read view of every select code, shared by both operand ports.
    always_comb begin
        for (int i = 0; i < 16; i++) rd[i] = 16'h0000;
        rd[0]  = {8'h00, bQ};
        rd[1]  = {8'h00, cQ};
        rd[2]  = {8'h00, dQ};
        rd[3]  = {8'h00, eQ};
        rd[4]  = {8'h00, hQ};
        rd[5]  = {8'h00, lQ};
        rd[6]  = {8'h00, fQ, 4'h0};
        rd[7]  = {8'h00, aQ};
        rd[8]  = {bQ, cQ};
        rd[9]  = {dQ, eQ};
        rd[10] = {hQ, lQ};
        rd[11] = spQ;
        rd[12] = {aQ, fQ, 4'h0};
        rd[13] = pcQ;
    end

    assign X     = rd[selX];
    assign Y     = rd[selY];
    assign flags = fQ;
    assign pc    = pcQ;

    // INC/DEC is dropped when the data write touches any byte of the same pair.
    always_comb begin
        idConflict = 1'b0;
        idPair     = spQ;
        unique case (idSel)
            2'd0: begin
                idPair     = {bQ, cQ};
                idConflict = wrEn && (wrSel == 4'd0 || wrSel == 4'd1 || wrSel == 4'd8);
            end
            2'd1: begin
                idPair     = {dQ, eQ};
                idConflict = wrEn && (wrSel == 4'd2 || wrSel == 4'd3 || wrSel == 4'd9);
            end
            2'd2: begin
                idPair     = {hQ, lQ};
                idConflict = wrEn && (wrSel == 4'd4 || wrSel == 4'd5 || wrSel == 4'd10);
            end
            2'd3: begin
                idPair     = spQ;
                idConflict = wrEn && (wrSel == 4'd11);
            end
        endcase
        idResult = idDec ? idPair - 16'd1 : idPair + 16'd1;
    end

    // Next state: INC/DEC, then data write, then flag merge, then PC.
    always_comb begin
        aD  = aQ;
        fD  = fQ;
        bD  = bQ;
        cD  = cQ;
        dD  = dQ;
        eD  = eQ;
        hD  = hQ;
        lD  = lQ;
        spD = spQ;
        pcD = pcQ;

        if (idEn && !idConflict) begin
            unique case (idSel)
                2'd0: {bD, cD} = idResult;
                2'd1: {dD, eD} = idResult;
                2'd2: {hD, lD} = idResult;
                2'd3: spD      = idResult;
            endcase
        end

        if (wrEn) begin
            case (wrSel)
                4'd0:  bD       = wrData[7:0];
                4'd1:  cD       = wrData[7:0];
                4'd2:  dD       = wrData[7:0];
                4'd3:  eD       = wrData[7:0];
                4'd4:  hD       = wrData[7:0];
                4'd5:  lD       = wrData[7:0];
                4'd6:  fD       = wrData[7:4];
                4'd7:  aD       = wrData[7:0];
                4'd8:  {bD, cD} = wrData;
                4'd9:  {dD, eD} = wrData;
                4'd10: {hD, lD} = wrData;
                4'd11: spD      = wrData;
                4'd12: begin
                    aD = wrData[15:8];
                    fD = wrData[7:4];
                end
                default: ;
            endcase
        end

        // Masked flags override whatever the data write put into F.
        if (flagWrEn) fD = (fD & ~flagMask) | (flagIn & flagMask);

        if (pcLoad)                      pcD = pcIn;
        else if (wrEn && wrSel == 4'd13) pcD = wrData;
        else if (pcInc)                  pcD = pcQ + 16'd1;
    end

    // State registers with synchronous reset dominating all updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            aQ  <= RstA;
            fQ  <= RstF;
            bQ  <= RstB;
            cQ  <= RstC;
            dQ  <= RstD;
            eQ  <= RstE;
            hQ  <= RstH;
            lQ  <= RstL;
            spQ <= RstSp;
            pcQ <= RstPc;
        end else begin
            aQ  <= aD;
            fQ  <= fD;
            bQ  <= bD;
            cQ  <= cD;
            dQ  <= dD;
            eQ  <= eD;
            hQ  <= hD;
            lQ  <= lD;
            spQ <= spD;
            pcQ <= pcD;
        end
    end

endmodule

// File: tb/tb_cpu_regbank.sv
// Scoreboard bench for cpu_regbank: two instances (zero reset and post-boot
// reset) share stimulus; expectations come from a byte-array reference model.
module tb_cpu_regbank;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  selX, selY, wrSel, flagMask, flagIn;
    logic        wrEn, flagWrEn, idEn, idDec, pcInc, pcLoad;
    logic [1:0]  idSel;
    logic [15:0] wrData, pcIn;

    logic [15:0] x0, y0, pc0, x1, y1, pc1;
    logic [3:0]  f0, f1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] x0, y0, pc0;
        logic [3:0]  f0;
        logic [15:0] x1, y1, pc1;
        logic [3:0]  f1;
    } exp_t;

    exp_t expQ[$];

    // Model state per instance: byte order B,C,D,E,H,L,F,A (same as 8-bit selects).
    logic [7:0]  mr  [2][8];
    logic [15:0] msp [2];
    logic [15:0] mpc [2];

    always #5 clk = ~clk;

    cpu_regbank #(.BOOT_SKIP(1'b0), .RESET_PC(16'h0150)) dut0 (
        .clk(clk), .reset(reset), .selX(selX), .selY(selY), .X(x0), .Y(y0), .flags(f0),
        .wrEn(wrEn), .wrSel(wrSel), .wrData(wrData), .flagWrEn(flagWrEn),
        .flagMask(flagMask), .flagIn(flagIn), .idEn(idEn), .idSel(idSel), .idDec(idDec),
        .pcInc(pcInc), .pcLoad(pcLoad), .pcIn(pcIn), .pc(pc0)
    );

    cpu_regbank #(.BOOT_SKIP(1'b1), .RESET_PC(16'h0150)) dut1 (
        .clk(clk), .reset(reset), .selX(selX), .selY(selY), .X(x1), .Y(y1), .flags(f1),
        .wrEn(wrEn), .wrSel(wrSel), .wrData(wrData), .flagWrEn(flagWrEn),
        .flagMask(flagMask), .flagIn(flagIn), .idEn(idEn), .idSel(idSel), .idDec(idDec),
        .pcInc(pcInc), .pcLoad(pcLoad), .pcIn(pcIn), .pc(pc1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mRead(input int k, input logic [3:0] sel);
        int s;
        s = sel;
        if (s < 8)  return {8'h00, mr[k][s]};
        if (s < 11) return {mr[k][2 * (s - 8)], mr[k][2 * (s - 8) + 1]};
        if (s == 11) return msp[k];
        if (s == 12) return {mr[k][7], mr[k][6]};
        if (s == 13) return mpc[k];
        return 16'h0000;
    endfunction

    // Applies one clock edge of the architectural rules to instance k.
    task automatic modelUpdate(input int k);
        logic [7:0]  nr [8];
        logic [15:0] nsp, npc;
        int wb0, wb1, lo, val, delta, s;
        bit wsp, conflict;
        if (reset) begin
            for (int i = 0; i < 8; i++) mr[k][i] = 8'h00;
            msp[k] = 16'h0000;
            mpc[k] = 16'h0150;
            if (k == 1) begin
                mr[1][1] = 8'h13; mr[1][3] = 8'hD8; mr[1][4] = 8'h01;
                mr[1][5] = 8'h4D; mr[1][6] = 8'hB0; mr[1][7] = 8'h01;
                msp[1] = 16'hFFFE;
                mpc[1] = 16'h0100;
            end
            return;
        end
        for (int i = 0; i < 8; i++) nr[i] = mr[k][i];
        nsp = msp[k];
        npc = mpc[k];
        s = wrSel;
        wb0 = -1; wb1 = -1; wsp = 0;
        if (wrEn) begin
            if (s < 8) wb0 = s;
            else if (s < 11) begin wb0 = 2 * (s - 8); wb1 = wb0 + 1; end
            else if (s == 11) wsp = 1;
            else if (s == 12) begin wb0 = 7; wb1 = 6; end
        end
        lo = 2 * int'(idSel);
        if (idSel == 2'd3) conflict = wsp;
        else conflict = (wb0 == lo) || (wb0 == lo + 1) || (wb1 == lo) || (wb1 == lo + 1);
        delta = idDec ? 65535 : 1;
        if (idEn && !conflict) begin
            if (idSel == 2'd3) nsp = 16'((int'(msp[k]) + delta) % 65536);
            else begin
                val = (int'(mr[k][lo]) * 256 + int'(mr[k][lo + 1]) + delta) % 65536;
                nr[lo]     = 8'(val / 256);
                nr[lo + 1] = 8'(val % 256);
            end
        end
        if (wrEn) begin
            if (s < 8) nr[s] = wrData[7:0];
            else if (s < 11) begin nr[wb0] = wrData[15:8]; nr[wb1] = wrData[7:0]; end
            else if (s == 11) nsp = wrData;
            else if (s == 12) begin nr[7] = wrData[15:8]; nr[6] = wrData[7:0]; end
        end
        nr[6] = nr[6] & 8'hF0;
        for (int i = 0; i < 4; i++)
            if (flagWrEn && flagMask[i]) nr[6][4 + i] = flagIn[i];
        if (pcLoad) npc = pcIn;
        else if (wrEn && s == 13) npc = wrData;
        else if (pcInc) npc = 16'((int'(mpc[k]) + 1) % 65536);
        for (int i = 0; i < 8; i++) mr[k][i] = nr[i];
        msp[k] = nsp;
        mpc[k] = npc;
    endtask

    // Expect the current cycle's outputs, advance the model, cross the edge.
    task automatic step();
        exp_t e;
        e.x0 = mRead(0, selX); e.y0 = mRead(0, selY); e.pc0 = mpc[0]; e.f0 = mr[0][6][7:4];
        e.x1 = mRead(1, selX); e.y1 = mRead(1, selY); e.pc1 = mpc[1]; e.f1 = mr[1][6][7:4];
        expQ.push_back(e);
        modelUpdate(0);
        modelUpdate(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] sx, input logic [3:0] sy);
        reset = 1'b0; wrEn = 1'b0; flagWrEn = 1'b0; idEn = 1'b0;
        pcInc = 1'b0; pcLoad = 1'b0;
        selX = sx; selY = sy;
    endtask

    task automatic randomInputs();
        int r;
        reset    = ($urandom_range(39, 0) == 0);
        selX     = 4'($urandom_range(15, 0));
        selY     = 4'($urandom_range(15, 0));
        wrEn     = 1'($urandom_range(1, 0));
        wrSel    = 4'($urandom_range(15, 0));
        r        = $urandom_range(3, 0);
        wrData   = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
        flagWrEn = 1'($urandom_range(1, 0));
        flagMask = 4'($urandom_range(15, 0));
        flagIn   = 4'($urandom_range(15, 0));
        idEn     = 1'($urandom_range(1, 0));
        idSel    = 2'($urandom_range(3, 0));
        idDec    = 1'($urandom_range(1, 0));
        pcInc    = 1'($urandom_range(1, 0));
        pcLoad   = ($urandom_range(7, 0) == 0);
        pcIn     = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
    endtask

    // Monitor: registered/combinational outputs are presented every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("dut0 X", x0, e.x0);
            check("dut0 Y", y0, e.y0);
            check("dut0 pc", pc0, e.pc0);
            check("dut0 flags", {12'h000, f0}, {12'h000, e.f0});
            check("dut1 X", x1, e.x1);
            check("dut1 Y", y1, e.y1);
            check("dut1 pc", pc1, e.pc1);
            check("dut1 flags", {12'h000, f1}, {12'h000, e.f1});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle(4'd0, 4'd0);
        wrSel = 4'd0; wrData = 16'h0000; flagMask = 4'h0; flagIn = 4'h0;
        idSel = 2'd0; idDec = 1'b0; pcIn = 16'h0000;
        reset = 1'b1;
        modelUpdate(0);
        modelUpdate(1);
        @(posedge clk);
        #1;

        // Post-reset readout (AF / HL).
        idle(4'd12, 4'd10); step();

        // F write with concurrent masked flag write.
        idle(4'd6, 4'd12);
        wrEn = 1'b1; wrSel = 4'd6; wrData = 16'h00FF;
        flagWrEn = 1'b1; flagMask = 4'b0001; flagIn = 4'b0000;
        step();
        idle(4'd6, 4'd12); step();

        // 16-bit wrap on INC and DEC.
        idle(4'd10, 4'd6); wrEn = 1'b1; wrSel = 4'd10; wrData = 16'hFFFF; step();
        idle(4'd10, 4'd6); idEn = 1'b1; idSel = 2'd2; idDec = 1'b0; step();
        idle(4'd10, 4'd6); wrEn = 1'b1; wrSel = 4'd9; wrData = 16'h0000; step();
        idle(4'd9, 4'd6); idEn = 1'b1; idSel = 2'd1; idDec = 1'b1; step();
        idle(4'd9, 4'd10); step();

        // INC discarded when a half of the pair is written.
        idle(4'd8, 4'd6); wrEn = 1'b1; wrSel = 4'd8; wrData = 16'h1234; step();
        idle(4'd8, 4'd6); idEn = 1'b1; idSel = 2'd0; idDec = 1'b0;
        wrEn = 1'b1; wrSel = 4'd1; wrData = 16'h0077; step();
        idle(4'd8, 4'd1); step();

        // PC priority and wrap.
        idle(4'd13, 4'd0); pcInc = 1'b1; pcLoad = 1'b1; pcIn = 16'hC000; step();
        idle(4'd13, 4'd0); pcInc = 1'b1; wrEn = 1'b1; wrSel = 4'd13; wrData = 16'h2000; step();
        idle(4'd13, 4'd0); pcLoad = 1'b1; pcIn = 16'hFFFF; step();
        idle(4'd13, 4'd0); pcInc = 1'b1; step();
        idle(4'd13, 4'd0); step();

        // No write bypass, then reset discarding a concurrent write.
        idle(4'd7, 4'd8); wrEn = 1'b1; wrSel = 4'd7; wrData = 16'h0042; step();
        idle(4'd7, 4'd8); step();
        idle(4'd8, 4'd12); reset = 1'b1; wrEn = 1'b1; wrSel = 4'd8; wrData = 16'hABCD;
        idEn = 1'b1; idSel = 2'd0; pcInc = 1'b1; step();
        idle(4'd8, 4'd12); step();

        for (int n = 0; n < 600; n++) begin
            randomInputs();
            step();
        end
        idle(4'd0, 4'd0);
        @(negedge clk);
        #1;
        check("scoreboard drained", 16'(expQ.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_regbank.md
Name: cpu_regbank

Overview:
Game Boy CPU register bank: A, F, B, C, D, E, H, L, SP and PC.
- Sources the ALU X/Y operands and the ALU flag input {Z,N,H,C}.
- Consumes the ALU result and flag output on registered write-back.
- Sits directly upstream and downstream of the ALU in the execute loop. Also performs the independent 16-bit INC/DEC (rr, HL+/HL-) and PC sequencing the control unit needs each cycle.

Parameters:
BOOT_SKIP, 0, 1 = reset loads DMG post-boot values instead of zeros
RESET_PC, 16'h0000, PC reset value when BOOT_SKIP=0 (PC=16'h0100 when BOOT_SKIP=1)

Ports:
clk  in  1  clock; the only clock
reset  in  1  synchronous reset, active-high
selX  in  4  X operand register select (encoding below)
selY  in  4  Y operand register select
X  out  16  X operand to ALU, combinational read
Y  out  16  Y operand to ALU, combinational read
flags  out  4  F[7:4] = {Z,N,H,C}, drives ALU fIn
wrEn  in  1  write-back enable
wrSel  in  4  write-back destination
wrData  in  16  write-back data (ALU O)
flagWrEn  in  1  flag write enable
flagMask  in  4  per-flag update mask {Z,N,H,C}
flagIn  in  4  new flags (ALU fOut)
idEn  in  1  16-bit increment/decrement enable
idSel  in  2  0=BC 1=DE 2=HL 3=SP
idDec  in  1  1=decrement, 0=increment
pcInc  in  1  PC <= PC+1
pcLoad  in  1  PC <= pcIn
pcIn  in  16  PC load value
pc  out  16  current PC, registered

Behaviour:
- Select encoding: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 F, 7 A, 8 BC, 9 DE, 10 HL, 11 SP, 12 AF, 13 PC, 14-15 constant zero.
- Reads:
  - X/Y are purely combinational from register state.
  - 8-bit selects zero-extend to {8'h00, reg}.
  - 16-bit selects return {high, low}.
  - No write bypass: a write is visible on X/Y the cycle after wrEn.
- Writes occur on rising clk only.
  - 8-bit sel writes wrData[7:0].
  - 16-bit sel writes wrData[15:0].
  - Selects 14-15: write ignored.
- F[3:0] is hard-wired 0. Writes to F or AF store wrData[7:4] in F[7:4] and discard bits [3:0].
- Flag write: F[7:4] bit i <= flagIn[i] where flagMask[i]=1; unmasked bits hold.
- Flag write in the same cycle as wrEn to F/AF: the flag write is applied after the data write, so masked bits take flagIn and unmasked bits take wrData.
- INC/DEC:
  - Selected pair <= pair ± 1, modulo 2^16: FFFF+1=0000, 0000-1=FFFF.
  - Never touches F.
- INC/DEC conflict: if wrEn targets any byte of the idSel pair (pair or either half; SP only via sel 11), the INC/DEC is discarded and the write is applied as normal.
- PC priority, highest first: pcLoad > wrEn with wrSel=13 > pcInc. PC wraps FFFF -> 0000.
- Reset (synchronous, dominates every other input in that cycle):
  - BOOT_SKIP=0: all registers 0, PC=RESET_PC.
  - BOOT_SKIP=1: A=01, F=B0, B=00, C=13, D=00, E=D8, H=01, L=4D, SP=FFFE, PC=0100.
  - Outputs follow combinationally from the reset state: flags = F[7:4]; X/Y = selected registers.
- Reset asserted mid-sequence discards that cycle's pending writes, INC/DEC and PC update.
- All of the following may act in the same cycle when they do not conflict per the rules above:
  - data write,
  - flag write,
  - INC/DEC of a different pair,
  - PC update.

Test Plan:
1. Reset with BOOT_SKIP=1, selX=12, selY=10 -> X=01B0, Y=014D, flags=4'hB, pc=0100 on the first cycle after reset.
2. wrEn, wrSel=6, wrData=00FF, plus flagWrEn, flagMask=4'b0001, flagIn=4'b0000 -> next cycle F=E0, flags=4'hE, selX=6 reads 00E0.
3. HL=FFFF, idEn, idSel=2, idDec=0 -> HL=0000. Then DE=0000, idSel=1, idDec=1 -> DE=FFFF. F unchanged in both cases.
4. BC=1234, idEn, idSel=0, idDec=0 with wrEn, wrSel=1, wrData=0077 in the same cycle -> BC=1277 (INC discarded).
5. pc=0100, pcInc + pcLoad, pcIn=C000 -> C000. Next cycle pcInc + wrEn, wrSel=13, wrData=2000 -> 2000. Then pcInc alone from FFFF -> 0000.
6. wrEn, wrSel=7, wrData=0042, selX=7 in the same cycle -> X holds the old A that cycle and 0042 the next. Assert reset together with wrEn, wrSel=8 -> BC=0000 (BOOT_SKIP=0).
